// File: rtl/alu_pkg.sv
// ============================================================================
// alu_pkg : shared types and helpers for the serial flag generator
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sfg_state_t;

    typedef struct packed {
        logic n;
        logic v;
        logic c;
        logic z;
    } alu_flags_t;

    function automatic int ndig(input int width, input int digit);
        return width / digit;
    endfunction

endpackage

`default_nettype wire

// File: rtl/digit_adder.sv
// ============================================================================
// digit_adder : one DIGIT-wide slice of the serial adder, exposing the carry
//               into its top bit so the overflow flag can be formed
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module digit_adder #(
    parameter int DIGIT = 8
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout,
    output logic             c_msb_in
);

    logic [DIGIT:0] w_full;

    assign w_full   = {1'b0, x} + {1'b0, y} + {{DIGIT{1'b0}}, cin};
    assign sum      = w_full[DIGIT-1:0];
    assign cout     = w_full[DIGIT];
    // Top sum bit is x^y^carry_in, so the carry into it is recovered by XOR.
    assign c_msb_in = w_full[DIGIT-1] ^ x[DIGIT-1] ^ y[DIGIT-1];

endmodule

`default_nettype wire

// File: rtl/serial_flag_gen.sv
// ============================================================================
// serial_flag_gen : digit-serial add/subtract producing N/V/C/Z flags
//                   optional slt/sltu outputs under SERIAL_FLAG_SLT_EN
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module serial_flag_gen
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
`ifdef SERIAL_FLAG_SLT_EN
    output logic             slt,
    output logic             sltu,
`endif
    output logic             FlagN,
    output logic             FlagV,
    output logic             FlagC,
    output logic             FlagZ
);

    localparam int NDIG = ndig(WIDTH, DIGIT);
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(NDIG - 1);

    generate
        if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
            $error("serial_flag_gen: WIDTH must be a multiple of DIGIT");
        end
    endgenerate

    sfg_state_t       state_q,  state_d;
    logic [WIDTH-1:0] a_q,      a_d;
    logic [WIDTH-1:0] b_q,      b_d;
    logic             carry_q,  carry_d;
    logic [CW-1:0]    cnt_q,    cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zacc_q,   zacc_d;
    alu_flags_t       flags_q,  flags_d;
`ifdef SERIAL_FLAG_SLT_EN
    logic             slt_q,    slt_d;
    logic             sltu_q,   sltu_d;
`endif

    logic [DIGIT-1:0] w_sum;
    logic             w_cout;
    logic             w_cmsb;
    logic             w_last;
    logic [WIDTH-1:0] w_res_shift;

    digit_adder #(
        .DIGIT (DIGIT)
    ) u_digit_adder (
        .x        (a_q[DIGIT-1:0]),
        .y        (b_q[DIGIT-1:0]),
        .cin      (carry_q),
        .sum      (w_sum),
        .cout     (w_cout),
        .c_msb_in (w_cmsb)
    );

    // Digits enter at the top of result and walk down, landing in place after NDIG steps.
    generate
        if (NDIG == 1) begin : g_single_digit
            assign w_res_shift = w_sum;
        end else begin : g_multi_digit
            assign w_res_shift = {w_sum, result_q[WIDTH-1:DIGIT]};
        end
    endgenerate

    assign w_last = (cnt_q == LAST_CNT);

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        zacc_d   = zacc_q;
        flags_d  = flags_q;
`ifdef SERIAL_FLAG_SLT_EN
        slt_d    = slt_q;
        sltu_d   = sltu_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d  = RUN;
                    a_d      = a;
                    b_d      = b ^ {WIDTH{sub}};
                    carry_d  = sub;
                    cnt_d    = '0;
                    result_d = '0;
                    zacc_d   = 1'b0;
                end else begin
                    state_d  = IDLE;
                end
            end
            RUN: begin
                a_d      = a_q >> DIGIT;
                b_d      = b_q >> DIGIT;
                carry_d  = w_cout;
                cnt_d    = cnt_q + 1'b1;
                result_d = w_res_shift;
                zacc_d   = zacc_q | (|w_sum);
                if (w_last) begin
                    state_d   = DONE;
                    flags_d.n = w_sum[DIGIT-1];
                    flags_d.v = w_cout ^ w_cmsb;
                    flags_d.c = w_cout;
                    flags_d.z = ~(zacc_q | (|w_sum));
`ifdef SERIAL_FLAG_SLT_EN
                    slt_d     = w_sum[DIGIT-1] ^ (w_cout ^ w_cmsb);
                    sltu_d    = ~w_cout;
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            zacc_q   <= 1'b0;
            flags_q  <= '0;
`ifdef SERIAL_FLAG_SLT_EN
            slt_q    <= 1'b0;
            sltu_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            zacc_q   <= zacc_d;
            flags_q  <= flags_d;
`ifdef SERIAL_FLAG_SLT_EN
            slt_q    <= slt_d;
            sltu_q   <= sltu_d;
`endif
        end
    end

    assign busy   = (state_q == RUN);
    assign done   = (state_q == DONE);
    assign result = result_q;
    assign FlagN  = flags_q.n;
    assign FlagV  = flags_q.v;
    assign FlagC  = flags_q.c;
    assign FlagZ  = flags_q.z;
`ifdef SERIAL_FLAG_SLT_EN
    assign slt    = slt_q;
    assign sltu   = sltu_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_serial_flag_gen.sv
// ============================================================================
// tb_serial_flag_gen : scoreboard bench for serial_flag_gen (WIDTH=32, DIGIT=8)
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_serial_flag_gen;

    localparam int WIDTH = 32;
    localparam int DIGIT = 8;
    localparam int NDIG  = WIDTH / DIGIT;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              sub   = 1'b0;
    logic [WIDTH-1:0]  a     = '0;
    logic [WIDTH-1:0]  b     = '0;
    logic              busy, done;
    logic [WIDTH-1:0]  result;
    logic              FlagN, FlagV, FlagC, FlagZ;
`ifdef SERIAL_FLAG_SLT_EN
    logic              slt, sltu;
`endif

    serial_flag_gen #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .sub    (sub),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
`ifdef SERIAL_FLAG_SLT_EN
        .slt    (slt),
        .sltu   (sltu),
`endif
        .FlagN  (FlagN),
        .FlagV  (FlagV),
        .FlagC  (FlagC),
        .FlagZ  (FlagZ)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [WIDTH-1:0] r;
        logic n, v, c, z, slt, sltu;
        int   due;
    } exp_t;

    exp_t q[$];
    int n_tests = 0;
    int n_fail  = 0;

    // Reference: true-integer arithmetic, flags derived from the mathematical result.
    function automatic exp_t model(input logic s, input logic [WIDTH-1:0] x,
                                   input logic [WIDTH-1:0] y, input int due);
        exp_t   e;
        longint sx, sy, t;
        longint unsigned ux, uy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = longint'(x);
        uy = longint'(y);
        t  = s ? (sx - sy) : (sx + sy);
        e.r    = s ? (x - y) : (x + y);
        e.n    = e.r[WIDTH-1];
        e.v    = (t > 64'sd2147483647) || (t < -64'sd2147483648);
        e.c    = s ? (ux >= uy) : ((ux + uy) > 64'hFFFF_FFFF);
        e.z    = (e.r == '0);
        e.slt  = (t < 0);
        e.sltu = ~e.c;
        e.due  = due;
        return e;
    endfunction

    task automatic chk(input string name, input logic [WIDTH-1:0] got,
                       input logic [WIDTH-1:0] expv);
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, expv, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && done === 1'b1) begin
            if (q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 expected no pending op (t=%0t)", $time);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("latency", WIDTH'(cyc), WIDTH'(e.due));
                chk("result", result, e.r);
                chk("FlagN", {31'b0, FlagN}, {31'b0, e.n});
                chk("FlagV", {31'b0, FlagV}, {31'b0, e.v});
                chk("FlagC", {31'b0, FlagC}, {31'b0, e.c});
                chk("FlagZ", {31'b0, FlagZ}, {31'b0, e.z});
`ifdef SERIAL_FLAG_SLT_EN
                chk("slt", {31'b0, slt}, {31'b0, e.slt});
                chk("sltu", {31'b0, sltu}, {31'b0, e.sltu});
`endif
            end
        end
    end

    // Called on a falling edge; returns one falling edge later with start released.
    task automatic issue(input logic s, input logic [WIDTH-1:0] x,
                         input logic [WIDTH-1:0] y, input bit accept);
        start = 1'b1;
        sub   = s;
        a     = x;
        b     = y;
        if (accept) q.push_back(model(s, x, y, cyc + 1 + NDIG));
        @(negedge clk);
        start = 1'b0;
        sub   = 1'($urandom);
        a     = $urandom;
        b     = $urandom;
        if (accept) chk("busy_after_start", {31'b0, busy}, 32'd1);
    endtask

    task automatic run(input logic s, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        issue(s, x, y, 1'b1);
        repeat (NDIG + 1) @(negedge clk);
    endtask

    function automatic logic [WIDTH-1:0] pick();
        logic [WIDTH-1:0] corner [5];
        corner = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
        if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    initial begin
        int gap;
        int t;
        repeat (3) @(negedge clk);
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_done", {31'b0, done}, 32'd0);
        chk("reset_result", result, 32'd0);
        chk("reset_flags", {28'b0, FlagN, FlagV, FlagC, FlagZ}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run(1'b1, 32'd5, 32'd7);
        run(1'b1, 32'h8000_0000, 32'd1);
        run(1'b0, 32'hFFFF_FFFF, 32'd1);
        run(1'b0, 32'h7FFF_FFFF, 32'd1);

        // A second start during RUN must be dropped entirely.
        issue(1'b1, 32'd1, 32'd2, 1'b1);
        @(negedge clk);
        start = 1'b1; sub = 1'b0; a = 32'hDEAD_BEEF; b = 32'h1234_5678;
        @(negedge clk);
        start = 1'b0;
        repeat (NDIG) @(negedge clk);

        // Reset during the second RUN cycle aborts with no done pulse.
        issue(1'b1, 32'h10, 32'h3, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        q.delete();
        #1;
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_done", {31'b0, done}, 32'd0);
        chk("abort_result", result, 32'd0);
        chk("abort_flags", {28'b0, FlagN, FlagV, FlagC, FlagZ}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (NDIG + 1) @(negedge clk);
        run(1'b1, 32'd3, 32'd3);

        // Back-to-back: new start issued in the DONE cycle.
        issue(1'b1, 32'd1, 32'd2, 1'b1);
        repeat (NDIG) @(negedge clk);
        issue(1'b1, 32'd9, 32'd4, 1'b1);
        repeat (NDIG + 1) @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            gap = $urandom_range(0, 2);
            issue(1'($urandom), pick(), pick(), 1'b1);
            repeat (NDIG + gap) @(negedge clk);
        end

        t = 0;
        while (q.size() != 0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL missing_done: got %0d pending ops expected 0", q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
